mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Main control FSM for the multicycle MIPS datapath. It decodes the 6-bit opcode held in the instruction register and steps through fetch, decode, execute, memory and writeback states. Each cycle it drives the datapath mux selects, register/memory write enables and the 2-bit `aluOp` field consumed by the ALU control decoder. Memory accesses use a simple ready handshake so the shared instruction/data memory may take multiple cycles.

## Interface
Parameters: none.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `opcode`  in  6  instr[31:26] from IR; sampled in DECODE
- `zero`  in  1  ALU zero flag (valid in BRANCH)
- `mem_ready`  in  1  memory completes the current access this cycle
- `pcWrite`  out  1  unconditional PC load
- `pcWriteCond`  out  1  PC load if `zero`
- `iorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `memRead`  out  1  memory read request
- `memWrite`  out  1  memory write request
- `irWrite`  out  1  IR load
- `memToReg`  out  1  regfile write data: 0 = ALUOut, 1 = MDR
- `regDst`  out  1  dest reg: 0 = rt, 1 = rd
- `regWrite`  out  1  regfile write enable
- `aluSrcA`  out  1  0 = PC, 1 = A
- `aluSrcB`  out  2  00 = B, 01 = 4, 10 = signext imm, 11 = signext imm << 2
- `aluOp`  out  2  00 add, 01 subtract, 10 use funct
- `pcSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `state`  out  4  current state encoding (debug)
- `illegal`  out  1  one-cycle pulse on an unsupported opcode

## Operation
- States (4-bit encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11.
- FETCH:
  - Outputs: `memRead`=1, `iorD`=0, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=00, `pcSource`=00.
  - `irWrite` and `pcWrite` are 1 only in the cycle `mem_ready`=1; that cycle also transitions to DECODE.
  - With `mem_ready`=0 the FSM holds in FETCH.
- DECODE: `aluSrcA`=0, `aluSrcB`=11, `aluOp`=00 (branch target precompute). Next state by opcode:
  - 100011 (lw) / 101011 (sw) → MEMADR
  - 000000 (R-type) → EXEC
  - 000100 (beq) → BRANCH
  - 000010 (j) → JUMP
  - 001000 (addi) → ADDIEX (only when `ADDI_EN` is defined)
  - any other opcode → FETCH, with `illegal`=1 for that cycle
- MEMADR: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00. Next state MEMRD if lw, MEMWR if sw; the opcode is re-read from the IR, which is stable.
- MEMRD: `memRead`=1, `iorD`=1. Holds until `mem_ready`, then goes to MEMWB.
- MEMWB: `regWrite`=1, `memToReg`=1, `regDst`=0 → FETCH.
- MEMWR: `memWrite`=1, `iorD`=1. Holds until `mem_ready`, then → FETCH.
- EXEC: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=10 → ALUWB.
- ALUWB: `regWrite`=1, `memToReg`=0, `regDst`=1 → FETCH.
- BRANCH: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=01, `pcWriteCond`=1, `pcSource`=01 → FETCH.
- JUMP: `pcWrite`=1, `pcSource`=10 → FETCH.
- ADDIEX: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=00 → ADDIWB.
- ADDIWB: `regWrite`=1, `memToReg`=0, `regDst`=0 → FETCH.
- Defaults: every output not listed for a state is 0.
- Output timing: outputs are combinational from `state`, plus `mem_ready` gating in FETCH only.
- Undefined state encodings (12–15) → FETCH next cycle, all enables 0.

## Timing
- Reset:
  - `reset`=1 at a rising edge sets `state`=FETCH.
  - While `reset` is high, `pcWrite`, `pcWriteCond`, `irWrite`, `memRead`, `memWrite`, `regWrite` and `illegal` are forced to 0 regardless of state.
  - All mux selects and `aluOp` read 0 during reset.
- Reset mid-instruction aborts it; no write enable is asserted in the reset cycle.
- Latency with `mem_ready` always 1: R-type 4, beq 3, j 3, addi 4, sw 4, lw 5 cycles.
- Each cycle of `mem_ready`=0 during FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_ready` is ignored in all other states.
- `memRead` and `memWrite` are never asserted in the same cycle.

## Configuration
- `ADDI_EN` defined: opcode 001000 follows DECODE → ADDIEX → ADDIWB → FETCH.
- `ADDI_EN` undefined: states 10 and 11 are not implemented, and opcode 001000 is handled as illegal (DECODE → FETCH with an `illegal` pulse).

## Test plan
- R-type, `mem_ready`=1: states 0,1,6,7,0. EXEC drives `aluOp`=10; ALUWB drives `regWrite`=1, `regDst`=1.
- lw with `mem_ready` low for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0. MEMWB drives `memToReg`=1; total 7 cycles.
- beq with `zero`=1, then `zero`=0: BRANCH drives `pcWriteCond`=1, `aluOp`=01, `pcSource`=01 in both cases; `pcWrite` stays 0.
- Opcode 111111: DECODE → FETCH, `illegal`=1 for exactly one cycle. Opcode 001000 also pulses `illegal` when built without `ADDI_EN`.
- Assert `reset` in MEMWR with `mem_ready`=1: `memWrite`=0 that cycle, `state`=0 next cycle.
- FETCH with `mem_ready`=0 for 3 cycles: `memRead`=1 throughout; `irWrite`=`pcWrite`=0 until the ready cycle, then 1 for exactly one cycle.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// mux selects, write enables and aluOp. Outputs are decoded combinationally
// from the current state, with mem_ready gating only the FETCH loads.
// Optional feature macro: ADDI_EN (adds ADDIEX/ADDIWB for opcode 001000).
module mips_multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q, state_d;

    // zero only feeds the datapath PC-load gate; the FSM itself never branches on it
    logic unused_zero;
    assign unused_zero = zero;

    assign state = state_q;

    // State register: reset forces FETCH, otherwise advance to the decoded next state
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and output decode; reset masks every output to 0 so an
    // aborted instruction can never commit a write in the reset cycle
    always_comb begin
        state_d     = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                if (mem_ready) begin
                    irWrite = 1'b1;
                    pcWrite = 1'b1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                // IR is stable, so the opcode is simply re-read here
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
                state_d  = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
`ifdef ADDI_EN
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
            end
`endif
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            iorD        = 1'b0;
            memRead     = 1'b0;
            memWrite    = 1'b0;
            irWrite     = 1'b0;
            memToReg    = 1'b0;
            regDst      = 1'b0;
            regWrite    = 1'b0;
            aluSrcA     = 1'b0;
            aluSrcB     = 2'b00;
            aluOp       = 2'b00;
            pcSource    = 2'b00;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed scenarios then
// random instruction streams with random memory stalls, checked against an
// instruction-level model (state path per opcode + per-state output table).
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       reset, zero, mem_ready;
    logic [5:0] opcode;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegal;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    int n_assert = 0;
    int n_fail   = 0;
    bit zero_v   = 1'b0;

    localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_J = 6'h02, OP_ADDI = 6'h08;

    always #5 clk = ~clk;

    mips_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regDst(regDst),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .state(state), .illegal(illegal)
    );

    logic [16:0] obs;
    assign obs = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                  regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegal};

    function automatic bit legal(logic [5:0] op);
        if (op == OP_LW || op == OP_SW || op == OP_R || op == OP_BEQ || op == OP_J) return 1'b1;
`ifdef ADDI_EN
        if (op == OP_ADDI) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Expected output bundle for a state, straight from the per-state output list
    function automatic logic [16:0] exp_out(int st, bit rdy, logic [5:0] op, bit rst);
        logic pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, ill} = '0;
        asb = 2'd0; aop = 2'd0; psrc = 2'd0;
        case (st)
            0:  begin mr = 1; asb = 2'd1; pw = rdy; irw = rdy; end
            1:  begin asb = 2'd3; ill = !legal(op); end
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'd2; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'd1; pwc = 1; psrc = 2'd1; end
            9:  begin pw = 1; psrc = 2'd2; end
            10: begin asa = 1; asb = 2'd2; end
            11: begin rw = 1; end
            default: ;
        endcase
        if (rst) return '0;
        return {pw, pwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc, ill};
    endfunction

    // Cycle count with no stalls, from the latency list (illegal: FETCH + DECODE)
    function automatic int base_lat(logic [5:0] op);
        case (op)
            OP_LW:  return 5;
            OP_SW:  return 4;
            OP_R:   return 4;
            OP_BEQ: return 3;
            OP_J:   return 3;
`ifdef ADDI_EN
            OP_ADDI: return 4;
`endif
            default: return 2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, o, e, $time);
        end
    endtask

    // One cycle: drive inputs just after posedge, check mid-cycle, advance
    task automatic step(input int st, input bit rdy, input bit rst, input logic [5:0] op);
        mem_ready = rdy; reset = rst; opcode = op; zero = zero_v;
        @(negedge clk);
        chk($sformatf("state op=%0h", op), {28'd0, state}, st);
        chk($sformatf("outs st=%0d op=%0h rdy=%0b rst=%0b", st, op, rdy, rst), {15'd0, obs},
            {15'd0, exp_out(st, rdy, op, rst)});
        @(posedge clk); #1;
    endtask

    // Run one instruction; fst/mst are forced stall counts in FETCH/memory,
    // rnd selects random stalls instead
    task automatic run_instr(input logic [5:0] op, input int fst, input int mst, input bit rnd);
        int p[$];
        int cyc = 0, nst = 0;
        p = {0, 1};
        case (op)
            OP_LW:  p = {0, 1, 2, 3, 4};
            OP_SW:  p = {0, 1, 2, 5};
            OP_R:   p = {0, 1, 6, 7};
            OP_BEQ: p = {0, 1, 8};
            OP_J:   p = {0, 1, 9};
`ifdef ADDI_EN
            OP_ADDI: p = {0, 1, 10, 11};
`endif
            default: ;
        endcase
        foreach (p[i]) begin
            bit ws, rdy;
            int stalls = 0;
            int lim;
            ws  = (p[i] == 0 || p[i] == 3 || p[i] == 5);
            lim = (p[i] == 0) ? fst : mst;
            do begin
                if (!ws)      rdy = 1'($urandom_range(0, 1));
                else if (rnd) rdy = (stalls >= 4) || ($urandom_range(0, 3) != 0);
                else          rdy = (stalls >= lim);
                step(p[i], rdy, 1'b0, op);
                cyc++;
                if (ws && !rdy) begin stalls++; nst++; end
            end while (ws && !rdy);
        end
        chk($sformatf("latency op=%0h", op), cyc, base_lat(op) + nst);
    endtask

    initial begin
        logic [5:0] ops [7];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'h3f};
        reset = 1'b1; mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
        @(posedge clk); #1;
        // reset state: FETCH with every output held low even though mem_ready=1
        step(0, 1'b1, 1'b1, OP_R);
        step(0, 1'b1, 1'b1, OP_LW);

        run_instr(OP_R, 0, 0, 1'b0);
        run_instr(OP_LW, 0, 2, 1'b0);
        zero_v = 1'b1; run_instr(OP_BEQ, 0, 0, 1'b0);
        zero_v = 1'b0; run_instr(OP_BEQ, 0, 0, 1'b0);
        run_instr(OP_J, 0, 0, 1'b0);
        run_instr(OP_SW, 0, 1, 1'b0);
        run_instr(6'h3f, 0, 0, 1'b0);
        run_instr(OP_ADDI, 0, 0, 1'b0);
        run_instr(OP_R, 3, 0, 1'b0);

        // reset while in MEMWR with mem_ready=1: no write, back to FETCH
        step(0, 1'b1, 1'b0, OP_SW);
        step(1, 1'b1, 1'b0, OP_SW);
        step(2, 1'b1, 1'b0, OP_SW);
        step(5, 1'b1, 1'b1, OP_SW);
        run_instr(OP_R, 0, 0, 1'b0);

        // reset in DECODE with an illegal opcode suppresses the illegal pulse
        step(0, 1'b1, 1'b0, 6'h3f);
        step(1, 1'b1, 1'b1, 6'h3f);
        run_instr(OP_J, 0, 0, 1'b0);

        for (int k = 0; k < 80; k++) begin
            logic [5:0] op;
            int sel;
            sel = $urandom_range(0, 7);
            op  = (sel == 7) ? 6'($urandom) : ops[sel];
            zero_v = 1'($urandom);
            run_instr(op, 0, 0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
